gemm_cmd_parser: RTL

- Generalised command-stream parser for the GEMM master controller.
- Consumes a word stream from the command FIFO, assembles one header word plus N payload words, and validates opcode and length.
- Emits one decoded command (op, id, zero-filled payload) on a valid/ready port to the dispatch logic.
- Successor to the fixed 32-bit parse path: word width and maximum payload size are parametrised; it adds length checking, skipping of malformed commands, sticky error flags and counters.

---
 rtl/gemm_pkg.sv | 79 +++++++
 rtl/gemm_cmd_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM command parser: header layout, opcode table,
// payload structs and the parser state encoding.
package gemm_pkg;

    localparam int unsigned HDR_OP_LSB  = 0;
    localparam int unsigned HDR_ID_LSB  = 8;
    localparam int unsigned HDR_LEN_LSB = 16;
    localparam int unsigned HDR_FLD_W   = 8;

    localparam logic [7:0] OP_FETCH     = 8'hF0;
    localparam logic [7:0] OP_DISP      = 8'hF1;
    localparam logic [7:0] OP_TILE      = 8'hF2;
    localparam logic [7:0] OP_WAIT_DISP = 8'hF3;
    localparam logic [7:0] OP_WAIT_TILE = 8'hF4;

    typedef struct packed {
        logic [31:0] dst_addr;
        logic [31:0] src_addr;
    } fetch_pay_t;

    typedef struct packed {
        logic [31:0] disp_cfg;
    } disp_pay_t;

    typedef struct packed {
        logic [31:0] k_dim;
        logic [31:0] n_dim;
        logic [31:0] m_dim;
    } tile_pay_t;

    typedef struct packed {
        logic [31:0] disp_tag;
    } wait_disp_pay_t;

    typedef struct packed {
        logic [31:0] tile_tag;
    } wait_tile_pay_t;

    localparam int unsigned FETCH_BYTES     = $bits(fetch_pay_t) / 8;
    localparam int unsigned DISP_BYTES      = $bits(disp_pay_t) / 8;
    localparam int unsigned TILE_BYTES      = $bits(tile_pay_t) / 8;
    localparam int unsigned WAIT_DISP_BYTES = $bits(wait_disp_pay_t) / 8;
    localparam int unsigned WAIT_TILE_BYTES = $bits(wait_tile_pay_t) / 8;

    typedef enum logic [1:0] {S_HDR, S_PAY, S_SKIP, S_OUT} parser_state_t;

    function automatic int unsigned bytes_to_words(input int unsigned nbytes,
                                                   input int unsigned word_w);
        return (nbytes + word_w / 8 - 1) / (word_w / 8);
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_FETCH) || (op == OP_DISP) || (op == OP_TILE) ||
               (op == OP_WAIT_DISP) || (op == OP_WAIT_TILE);
    endfunction

    // Zero for unknown opcodes; callers check op_known first.
    function automatic int unsigned exp_words(input logic [7:0] op, input int unsigned word_w);
        case (op)
            OP_FETCH:     return bytes_to_words(FETCH_BYTES, word_w);
            OP_DISP:      return bytes_to_words(DISP_BYTES, word_w);
            OP_TILE:      return bytes_to_words(TILE_BYTES, word_w);
            OP_WAIT_DISP: return bytes_to_words(WAIT_DISP_BYTES, word_w);
            OP_WAIT_TILE: return bytes_to_words(WAIT_TILE_BYTES, word_w);
            default:      return 0;
        endcase
    endfunction

    function automatic int unsigned max_exp_words(input int unsigned word_w);
        int unsigned m;
        m = exp_words(OP_FETCH, word_w);
        if (exp_words(OP_DISP, word_w) > m)      m = exp_words(OP_DISP, word_w);
        if (exp_words(OP_TILE, word_w) > m)      m = exp_words(OP_TILE, word_w);
        if (exp_words(OP_WAIT_DISP, word_w) > m) m = exp_words(OP_WAIT_DISP, word_w);
        if (exp_words(OP_WAIT_TILE, word_w) > m) m = exp_words(OP_WAIT_TILE, word_w);
        return m;
    endfunction

endpackage

// File: rtl/gemm_cmd_parser.sv
// Command-stream parser: assembles header + payload words, validates opcode and
// length, skips malformed commands and presents decoded commands on valid/ready.
module gemm_cmd_parser
    import gemm_pkg::*;
#(
    parameter int unsigned WORD_W        = 32,
    parameter int unsigned MAX_PAY_WORDS = 3,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [WORD_W-1:0]               i_word_data,
    input  logic                            i_word_valid,
    output logic                            o_word_ready,
    output logic                            o_cmd_valid,
    input  logic                            i_cmd_ready,
    output logic [7:0]                      o_cmd_op,
    output logic [7:0]                      o_cmd_id,
    output logic [MAX_PAY_WORDS*WORD_W-1:0] o_cmd_payload,
    output logic                            o_err_unknown_op,
    output logic                            o_err_len,
    input  logic                            i_err_clear,
    output logic [CNT_W-1:0]                o_cmd_count,
    output logic [CNT_W-1:0]                o_err_count
);

    localparam int unsigned PAY_W = MAX_PAY_WORDS * WORD_W;
    localparam int unsigned IDX_W = $clog2(MAX_PAY_WORDS + 1);

    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("gemm_cmd_parser: WORD_W must be 32 or 64");
    end
    if (MAX_PAY_WORDS < max_exp_words(WORD_W)) begin : g_bad_depth
        $error("gemm_cmd_parser: MAX_PAY_WORDS too small for the opcode table");
    end

    parser_state_t     state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [7:0]        id_q, id_d;
    logic [PAY_W-1:0]  pay_q, pay_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        skip_q, skip_d;
    logic              unk_q, unk_d;
    logic              len_q, len_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [7:0]  hdr_op, hdr_id, hdr_len;
    logic [31:0] hdr_words;
    logic        word_fire;
    logic        set_unk, set_len, err_inc;

    assign hdr_op    = i_word_data[HDR_OP_LSB +: HDR_FLD_W];
    assign hdr_id    = i_word_data[HDR_ID_LSB +: HDR_FLD_W];
    assign hdr_len   = i_word_data[HDR_LEN_LSB +: HDR_FLD_W];
    assign hdr_words = bytes_to_words(32'(hdr_len), WORD_W);

    assign o_word_ready = (state_q != S_OUT);
    assign word_fire    = i_word_valid && o_word_ready;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        id_d      = id_q;
        pay_d     = pay_q;
        idx_d     = idx_q;
        skip_d    = skip_q;
        cmd_cnt_d = cmd_cnt_q;
        set_unk   = 1'b0;
        set_len   = 1'b0;
        err_inc   = 1'b0;

        case (state_q)
            S_HDR: begin
                if (word_fire) begin
                    op_d  = hdr_op;
                    id_d  = hdr_id;
                    pay_d = '0;
                    idx_d = '0;
                    if (!op_known(hdr_op)) begin
                        set_unk = 1'b1;
                    end else if (hdr_words != exp_words(hdr_op, WORD_W)) begin
                        set_len = 1'b1;
                    end
                    if (set_unk || set_len) begin
                        // Zero-length malformed headers have nothing to skip.
                        if (hdr_words == 32'd0) begin
                            err_inc = 1'b1;
                        end else begin
                            state_d = S_SKIP;
                            skip_d  = 8'(hdr_words);
                        end
                    end else begin
                        state_d = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (word_fire) begin
                    for (int unsigned k = 0; k < MAX_PAY_WORDS; k++) begin
                        if (32'(idx_q) == k) begin
                            pay_d[k*WORD_W +: WORD_W] = i_word_data;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    if (32'(idx_q) + 32'd1 == exp_words(op_q, WORD_W)) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_SKIP: begin
                if (word_fire) begin
                    skip_d = skip_q - 8'd1;
                    if (skip_q == 8'd1) begin
                        err_inc = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_OUT: begin
                if (i_cmd_ready) begin
                    state_d   = S_HDR;
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                end
            end
            default: state_d = S_HDR;
        endcase

        // A new error in the clearing cycle survives the clear.
        unk_d = set_unk | (unk_q & ~i_err_clear);
        len_d = set_len | (len_q & ~i_err_clear);
        if (i_err_clear) begin
            err_cnt_d = err_inc ? CNT_W'(1) : '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_HDR;
            op_q      <= '0;
            id_q      <= '0;
            pay_q     <= '0;
            idx_q     <= '0;
            skip_q    <= '0;
            unk_q     <= 1'b0;
            len_q     <= 1'b0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            id_q      <= id_d;
            pay_q     <= pay_d;
            idx_q     <= idx_d;
            skip_q    <= skip_d;
            unk_q     <= unk_d;
            len_q     <= len_d;
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_cmd_valid      = (state_q == S_OUT);
    assign o_cmd_op         = op_q;
    assign o_cmd_id         = id_q;
    assign o_cmd_payload    = pay_q;
    assign o_err_unknown_op = unk_q;
    assign o_err_len        = len_q;
    assign o_cmd_count      = cmd_cnt_q;
    assign o_err_count      = err_cnt_q;

endmodule
